speed_pwm_ramp: RTL and testbench

SPEED_PWM_RAMP -- requirements
Module: speed_pwm_ramp

---
 rtl/speed_pwm_ramp.sv | 183 ++++++++++++++++++
 tb/tb_speed_pwm_ramp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/speed_pwm_ramp.sv
// Motor speed controller: debounces a 2-bit speed code, maps it to a target duty,
// ramps the applied duty toward it in timed steps and drives a glitch-free PWM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | duty is 0 and no non-zero target is pending
// RAMP_UP   | stepping duty up toward target_duty on each ramp tick
// RAMP_DOWN | stepping duty down toward target_duty on each ramp tick
// HOLD      | duty has reached a non-zero target_duty and is held there
module speed_pwm_ramp #(
    parameter int PWM_BITS      = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter int RAMP_DIV      = 50000,
    parameter int STEP          = 5,
    parameter int DUTY0         = 0,
    parameter int DUTY1         = 85,
    parameter int DUTY2         = 170,
    parameter int DUTY3         = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          speed_in,
    input  logic                enable,
    input  logic                estop,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic [PWM_BITS-1:0] target_duty,
    output logic                at_target,
    output logic [1:0]          fsm_state
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV + 1) : 1;

    localparam logic [STAB_W-1:0]   STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RAMP_DOWN = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          candidate;
    logic [1:0]          committed;
    logic [STAB_W-1:0]   stab_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] mapped_duty;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;
    logic [PWM_BITS:0]   duty_ext;
    logic [PWM_BITS:0]   tgt_ext;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_duty;

    // Speed code must hold unchanged for STABLE_CYCLES before it is committed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            candidate <= '0;
            stab_cnt  <= '0;
            committed <= '0;
        end else if (speed_in != candidate) begin
            candidate <= speed_in;
            stab_cnt  <= '0;
        end else if (stab_cnt == STAB_LAST) begin
            committed <= candidate;
        end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
        end
    end

    always_comb begin
        mapped_duty = '0;
        case (committed)
            2'd0:    mapped_duty = PWM_BITS'(DUTY0);
            2'd1:    mapped_duty = PWM_BITS'(DUTY1);
            2'd2:    mapped_duty = PWM_BITS'(DUTY2);
            default: mapped_duty = PWM_BITS'(DUTY3);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            target_duty <= '0;
        else if (enable && !estop)
            target_duty <= mapped_duty;
        else
            target_duty <= '0;
    end

    // Free-running ramp timer; tick fires at terminal count and reloads.
    assign tick = (ramp_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset)
            ramp_cnt <= '0;
        else if (tick)
            ramp_cnt <= RAMP_LAST;
        else
            ramp_cnt <= ramp_cnt - RAMP_W'(1);
    end

    // One extra bit keeps the step arithmetic from wrapping past either rail.
    always_comb begin
        duty_ext = {1'b0, duty};
        tgt_ext  = {1'b0, target_duty};
        up_sum   = duty_ext + STEP_EXT;
        duty_up  = (up_sum >= tgt_ext) ? target_duty : up_sum[PWM_BITS-1:0];
        duty_dn  = (duty_ext <= tgt_ext + STEP_EXT) ? target_duty : (duty - STEP_N);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            duty  <= '0;
        end else if (estop) begin
            state <= S_IDLE;
            duty  <= '0;
        end else if (duty == '0 && target_duty == '0) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (target_duty != '0)
                        state <= S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (target_duty < duty)
                        state <= S_RAMP_DOWN;
                    else if (target_duty == duty)
                        state <= S_HOLD;
                    else if (tick)
                        duty <= duty_up;
                end
                S_RAMP_DOWN: begin
                    if (target_duty > duty)
                        state <= S_RAMP_UP;
                    else if (target_duty == duty)
                        state <= S_HOLD;
                    else if (tick)
                        duty <= duty_dn;
                end
                S_HOLD: begin
                    if (target_duty < duty)
                        state <= S_RAMP_DOWN;
                    else if (target_duty > duty)
                        state <= S_RAMP_UP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state = state;
    assign at_target = (state == S_HOLD) && (duty == target_duty);

    // Compare duty is reloaded only as the counter wraps, so a period never mixes two duties.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt  <= '0;
            pwm_duty <= '0;
            pwm_out  <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
            if (estop) begin
                pwm_duty <= '0;
                pwm_out  <= 1'b0;
            end else begin
                if (pwm_cnt == PWM_LAST)
                    pwm_duty <= duty;
                pwm_out <= (pwm_cnt < pwm_duty);
            end
        end
    end

endmodule

// File: tb/tb_speed_pwm_ramp.sv
// Bench for speed_pwm_ramp: cycle table with scoreboard queue for the ramp/FSM
// sequences, then PWM duty-shape measurements at 255, 85 and 0.
module tb_speed_pwm_ramp;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] speed_in = 2'd0;
    logic       enable = 1'b0;
    logic       estop = 1'b0;
    logic       pwm_out;
    logic [7:0] duty;
    logic [7:0] target_duty;
    logic       at_target;
    logic [1:0] fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    speed_pwm_ramp #(
        .PWM_BITS(8),
        .STABLE_CYCLES(4),
        .RAMP_DIV(2),
        .STEP(85)
    ) dut (
        .clk(clk),
        .reset(reset),
        .speed_in(speed_in),
        .enable(enable),
        .estop(estop),
        .pwm_out(pwm_out),
        .duty(duty),
        .target_duty(target_duty),
        .at_target(at_target),
        .fsm_state(fsm_state)
    );

    typedef struct {
        int spd;
        int en;
        int es;
        int rst;
        int e_duty;
        int e_state;
        int e_tgt;
        int e_at;
        int chk_pwm;
    } vec_t;

    typedef struct {
        int idx;
        int e_duty;
        int e_state;
        int e_tgt;
        int e_at;
        int chk_pwm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void row(input int n, input int spd, input int en, input int es,
                                input int rst, input int d, input int st, input int tg,
                                input int at, input int cp);
        vec_t v;
        v.spd = spd; v.en = en; v.es = es; v.rst = rst;
        v.e_duty = d; v.e_state = st; v.e_tgt = tg; v.e_at = at; v.chk_pwm = cp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (pwm_out) hi++;
        end
    endtask

    task automatic wait_state(input int st, input int d, input int budget, output int ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (int'(fsm_state) == st && int'(duty) == d) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   hi;
        int   ok;

        // n, spd, en, es, rst | duty, state, target, at_target, check pwm_out==0
        row(2, 0, 1, 0, 0,   0, 0,   0, 0, 1);
        row(5, 3, 1, 0, 1,   0, 0,   0, 0, 0);
        row(1, 3, 1, 0, 1,   0, 0, 255, 0, 0);
        row(2, 3, 1, 0, 1,   0, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1,  85, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1, 170, 1, 255, 0, 0);
        row(1, 3, 1, 0, 1, 255, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1, 255, 3, 255, 1, 0);
        // 3-cycle glitch to code 0 must not commit
        row(3, 0, 1, 0, 1, 255, 3, 255, 1, 0);
        row(6, 3, 1, 0, 1, 255, 3, 255, 1, 0);
        // ramp down to code 1
        row(5, 1, 1, 0, 1, 255, 3, 255, 1, 0);
        row(1, 1, 1, 0, 1, 255, 3,  85, 0, 0);
        row(2, 1, 1, 0, 1, 255, 2,  85, 0, 0);
        row(2, 1, 1, 0, 1, 170, 2,  85, 0, 0);
        row(1, 1, 1, 0, 1,  85, 2,  85, 0, 0);
        row(2, 1, 1, 0, 1,  85, 3,  85, 1, 0);
        // back up to code 3, estop while RAMP_UP at 85
        row(5, 3, 1, 0, 1,  85, 3,  85, 1, 0);
        row(1, 3, 1, 0, 1,  85, 3, 255, 0, 0);
        row(1, 3, 1, 0, 1,  85, 1, 255, 0, 0);
        row(1, 3, 1, 1, 1,   0, 0,   0, 0, 1);
        row(1, 3, 1, 0, 1,   0, 0, 255, 0, 0);
        row(2, 3, 1, 0, 1,   0, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1,  85, 1, 255, 0, 0);
        // reset mid-ramp, then a fresh commit is required
        row(1, 3, 1, 0, 0,   0, 0,   0, 0, 1);
        row(5, 3, 1, 0, 1,   0, 0,   0, 0, 0);
        row(1, 3, 1, 0, 1,   0, 0, 255, 0, 0);
        row(2, 3, 1, 0, 1,   0, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1,  85, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1, 170, 1, 255, 0, 0);
        row(1, 3, 1, 0, 1, 255, 1, 255, 0, 0);
        row(2, 3, 1, 0, 1, 255, 3, 255, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            speed_in = 2'(vecs[i].spd);
            enable   = (vecs[i].en != 0);
            estop    = (vecs[i].es != 0);
            reset    = (vecs[i].rst != 0);
            e.idx     = i;
            e.e_duty  = vecs[i].e_duty;
            e.e_state = vecs[i].e_state;
            e.e_tgt   = vecs[i].e_tgt;
            e.e_at    = vecs[i].e_at;
            e.chk_pwm = vecs[i].chk_pwm;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("row%0d duty", e.idx), int'(duty), e.e_duty);
            check($sformatf("row%0d state", e.idx), int'(fsm_state), e.e_state);
            check($sformatf("row%0d target_duty", e.idx), int'(target_duty), e.e_tgt);
            check($sformatf("row%0d at_target", e.idx), int'(at_target), e.e_at);
            if (e.chk_pwm != 0)
                check($sformatf("row%0d pwm_out", e.idx), int'(pwm_out), 0);
        end

        // PWM shape at duty 255: always high
        repeat (520) @(posedge clk);
        count_high(255, hi);
        check("pwm highs at duty 255", hi, 255);

        @(negedge clk);
        speed_in = 2'd1;
        wait_state(3, 85, 100, ok);
        check("hold at 85 reached", ok, 1);
        repeat (520) @(posedge clk);
        count_high(255, hi);
        check("pwm highs at duty 85", hi, 85);
        count_high(255, hi);
        check("pwm highs at duty 85 second period", hi, 85);

        @(negedge clk);
        enable = 1'b0;
        wait_state(0, 0, 100, ok);
        check("idle at duty 0 after disable", ok, 1);
        check("target_duty with enable low", int'(target_duty), 0);
        repeat (520) @(posedge clk);
        count_high(255, hi);
        check("pwm highs at duty 0", hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
